// File: rtl/dcache_pkg.sv
// Shared types and field widths for the direct-mapped data cache.
// Address split: {tag[2:0], index[2:0], offset[1:0]}; one 32-bit line per index.
package dcache_pkg;

   localparam int ADDR_W      = 8;
   localparam int BYTE_W      = 8;
   localparam int OFFSET_W    = 2;
   localparam int INDEX_W     = 3;
   localparam int TAG_W       = ADDR_W - INDEX_W - OFFSET_W;
   localparam int NUM_LINES   = 1 << INDEX_W;
   localparam int BLOCK_BYTES = 1 << OFFSET_W;
   localparam int LINE_W      = BLOCK_BYTES * BYTE_W;
   localparam int MEM_ADDR_W  = TAG_W + INDEX_W;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      ALLOCATE,
      UPDATE
   } state_e;

   // Bit position of the byte lane selected by a line offset.
   function automatic logic [4:0] lane_lsb(input logic [OFFSET_W-1:0] off);
      return {off, 3'b000};
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage (valid/dirty/tag/data), hit compare and byte read mux.
// Ports: index/tag/offset lookup, hit + rdata, victim info, byte write, line fill.
module dcache_array
   import dcache_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [INDEX_W-1:0]    index,
   input  logic [TAG_W-1:0]      tag,
   input  logic [OFFSET_W-1:0]   offset,
   output logic                  hit,
   output logic [BYTE_W-1:0]     rdata,
   output logic                  victim_dirty,
   output logic [TAG_W-1:0]      victim_tag,
   output logic [LINE_W-1:0]     victim_data,
   input  logic                  wr_en,
   input  logic [BYTE_W-1:0]     wr_byte,
   input  logic                  fill_en,
   input  logic [LINE_W-1:0]     fill_data
);

   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [NUM_LINES-1:0] dirty_q, dirty_d;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [TAG_W-1:0]     tag_d  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];
   logic [LINE_W-1:0]    data_d [NUM_LINES];

   assign hit          = valid_q[index] && (tag_q[index] == tag);
   assign rdata        = hit ? data_q[index][lane_lsb(offset) +: BYTE_W]
                             : '0;
   assign victim_dirty = valid_q[index] && dirty_q[index];
   assign victim_tag   = tag_q[index];
   assign victim_data  = data_q[index];

   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (fill_en) begin
         valid_d[index] = 1'b1;
         dirty_d[index] = 1'b0;
         tag_d[index]   = tag;
         data_d[index]  = fill_data;
      end else if (wr_en) begin
         data_d[index][lane_lsb(offset) +: BYTE_W] = wr_byte;
         dirty_d[index] = 1'b1;
      end
   end

   // Tags and data need no reset: nothing reads them while the line is invalid.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
      tag_q  <= tag_d;
      data_q <= data_d;
   end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back write-allocate data cache: CPU byte port in, 32-bit block memory out.
// Ports: CLK, RESET, CPU READ/WRITE/ADDRESS/WRITEDATA/READDATA/BUSYWAIT, MEM_* block interface.
module data_cache
   import dcache_pkg::*;
(
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   READ,
   input  logic                   WRITE,
   input  logic [ADDR_W-1:0]      ADDRESS,
   input  logic [BYTE_W-1:0]      WRITEDATA,
   output logic [BYTE_W-1:0]      READDATA,
   output logic                   BUSYWAIT,
   output logic                   MEM_READ,
   output logic                   MEM_WRITE,
   output logic [MEM_ADDR_W-1:0]  MEM_ADDRESS,
   output logic [LINE_W-1:0]      MEM_WRITEDATA,
   input  logic [LINE_W-1:0]      MEM_READDATA,
   input  logic                   MEM_BUSYWAIT
);

   logic [TAG_W-1:0]    req_tag;
   logic [INDEX_W-1:0]  req_index;
   logic [OFFSET_W-1:0] req_offset;
   logic                req;
   logic                hit;
   logic                victim_dirty;
   logic [TAG_W-1:0]    victim_tag;
   logic [LINE_W-1:0]   victim_data;
   logic                wr_en;
   logic                fill_en;

   state_e state_q, state_d;
   // High in the first cycle of a state: memory cannot have raised busy yet.
   logic   first_q, first_d;

   assign req_tag    = ADDRESS[ADDR_W-1 -: TAG_W];
   assign req_index  = ADDRESS[OFFSET_W +: INDEX_W];
   assign req_offset = ADDRESS[OFFSET_W-1:0];
   assign req        = READ || WRITE;

   // A store wins when READ and WRITE are both high.
   assign wr_en   = (state_q == IDLE) && WRITE && hit;
   assign fill_en = (state_q == UPDATE);

   dcache_array u_array (
      .CLK          (CLK),
      .RESET        (RESET),
      .index        (req_index),
      .tag          (req_tag),
      .offset       (req_offset),
      .hit          (hit),
      .rdata        (READDATA),
      .victim_dirty (victim_dirty),
      .victim_tag   (victim_tag),
      .victim_data  (victim_data),
      .wr_en        (wr_en),
      .wr_byte      (WRITEDATA),
      .fill_en      (fill_en),
      .fill_data    (MEM_READDATA)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req && !hit)
               state_d = victim_dirty ? WRITEBACK : ALLOCATE;
         end
         WRITEBACK: begin
            if (!first_q && !MEM_BUSYWAIT)
               state_d = ALLOCATE;
         end
         ALLOCATE: begin
            if (!first_q && !MEM_BUSYWAIT)
               state_d = UPDATE;
         end
         UPDATE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      first_d = (state_d != state_q);
   end

   always_comb begin
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = '0;
      MEM_WRITEDATA = '0;
      unique case (state_q)
         WRITEBACK: begin
            MEM_WRITE     = 1'b1;
            MEM_ADDRESS   = {victim_tag, req_index};
            MEM_WRITEDATA = victim_data;
         end
         ALLOCATE: begin
            MEM_READ    = 1'b1;
            MEM_ADDRESS = {req_tag, req_index};
         end
         default: ;
      endcase
      BUSYWAIT = !RESET && ((state_q != IDLE) || (req && !hit));
   end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: reference cache model, latency-varying memory model.
// Ports: drives all data_cache inputs, checks CPU responses and memory transactions.
module tb_data_cache;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        READ;
   logic        WRITE;
   logic [7:0]  ADDRESS;
   logic [7:0]  WRITEDATA;
   logic [7:0]  READDATA;
   logic        BUSYWAIT;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [5:0]  MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA;
   logic [31:0] MEM_READDATA;
   logic        MEM_BUSYWAIT;

   always #5 CLK = ~CLK;

   data_cache dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .READ          (READ),
      .WRITE         (WRITE),
      .ADDRESS       (ADDRESS),
      .WRITEDATA     (WRITEDATA),
      .READDATA      (READDATA),
      .BUSYWAIT      (BUSYWAIT),
      .MEM_READ      (MEM_READ),
      .MEM_WRITE     (MEM_WRITE),
      .MEM_ADDRESS   (MEM_ADDRESS),
      .MEM_WRITEDATA (MEM_WRITEDATA),
      .MEM_READDATA  (MEM_READDATA),
      .MEM_BUSYWAIT  (MEM_BUSYWAIT)
   );

   typedef struct {
      bit       rd;
      bit [7:0] data;
      int       stall;
   } exp_t;

   typedef struct {
      bit        wr;
      bit [5:0]  addr;
      bit [31:0] data;
   } mop_t;

   exp_t exp_q[$];
   mop_t mop_q[$];
   int   lat_q[$];

   int n_chk  = 0;
   int n_fail = 0;

   bit [31:0] dev_mem [64];
   bit [31:0] ref_mem [64];
   bit        m_valid [8];
   bit        m_dirty [8];
   int        m_tag   [8];
   bit [31:0] m_data  [8];

   function automatic void chk(string nm, longint act, longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // ---------------- memory device ----------------
   bit        mem_busy;
   int        mem_cnt;
   bit        op_wr;
   bit [5:0]  op_addr;
   bit [31:0] op_data;
   bit        prev_r, prev_w;

   always @(negedge CLK) begin
      if (RESET) begin
         mem_busy <= 1'b0;
         prev_r   <= 1'b0;
         prev_w   <= 1'b0;
      end else begin
         if (MEM_READ || MEM_WRITE)
            chk("one_strobe", MEM_READ && MEM_WRITE, 0);
         if (mem_busy) begin
            if (mem_cnt == 1) begin
               mem_busy <= 1'b0;
               if (op_wr) dev_mem[op_addr] <= op_data;
               else       MEM_READDATA     <= dev_mem[op_addr];
            end else begin
               mem_cnt <= mem_cnt - 1;
            end
         end else if ((MEM_READ && !prev_r) || (MEM_WRITE && !prev_w)) begin
            mop_t m;
            int   l;
            op_wr   <= MEM_WRITE;
            op_addr <= MEM_ADDRESS;
            op_data <= MEM_WRITEDATA;
            if (mop_q.size() == 0) begin
               chk("unexpected_mem_op", {MEM_WRITE, MEM_ADDRESS}, 0);
            end else begin
               m = mop_q.pop_front();
               chk("mem_op_is_write", MEM_WRITE, m.wr);
               chk("mem_addr", MEM_ADDRESS, m.addr);
               if (m.wr) chk("mem_wdata", MEM_WRITEDATA, m.data);
            end
            l = (lat_q.size() != 0) ? lat_q.pop_front() : 5;
            mem_cnt  <= l - 1;
            mem_busy <= 1'b1;
         end
         prev_r <= MEM_READ;
         prev_w <= MEM_WRITE;
      end
   end

   assign MEM_BUSYWAIT = mem_busy;

   // ---------------- CPU-side monitor ----------------
   int stall = 0;

   always @(negedge CLK) begin
      if (RESET) begin
         stall <= 0;
      end else if (READ || WRITE) begin
         if (BUSYWAIT) begin
            stall <= stall + 1;
         end else if (exp_q.size() == 0) begin
            chk("exp_q_empty", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall_cycles", stall, e.stall);
            if (e.rd) chk("readdata", READDATA, e.data);
            stall <= 0;
         end
      end
   end

   // ---------------- reference model + driver ----------------
   function automatic int pick_lat(bit rnd);
      return rnd ? int'($urandom_range(2, 6)) : 5;
   endfunction

   task automatic issue(input bit rd, input bit wr, input int a,
                        input int wd, input bit rnd);
      int   t, i, o, l;
      exp_t e;
      t = a / 32;
      i = (a / 4) % 8;
      o = a % 4;
      e.stall = 0;
      if (!(m_valid[i] && m_tag[i] == t)) begin
         e.stall = 2;
         if (m_valid[i] && m_dirty[i]) begin
            l = pick_lat(rnd);
            lat_q.push_back(l);
            mop_q.push_back('{1'b1, 6'(m_tag[i] * 8 + i), m_data[i]});
            ref_mem[m_tag[i] * 8 + i] = m_data[i];
            e.stall += l;
         end
         l = pick_lat(rnd);
         lat_q.push_back(l);
         mop_q.push_back('{1'b0, 6'(t * 8 + i), 32'h0});
         e.stall += l;
         m_valid[i] = 1'b1;
         m_dirty[i] = 1'b0;
         m_tag[i]   = t;
         m_data[i]  = ref_mem[t * 8 + i];
      end
      e.rd   = rd && !wr;
      e.data = 8'((m_data[i] >> (8 * o)) & 32'hFF);
      if (wr) begin
         m_data[i] = (m_data[i] & ~(32'hFF << (8 * o)))
                   | (32'(wd & 8'hFF) << (8 * o));
         m_dirty[i] = 1'b1;
      end
      exp_q.push_back(e);
      READ      = rd;
      WRITE     = wr;
      ADDRESS   = 8'(a);
      WRITEDATA = 8'(wd);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (BUSYWAIT && n < 200);
      if (BUSYWAIT) chk("busywait_timeout", 1, 0);
      @(posedge CLK);
      #1;
      READ  = 1'b0;
      WRITE = 1'b0;
   endtask

   task automatic do_req(input bit rd, input bit wr, input int a,
                         input int wd, input bit rnd);
      issue(rd, wr, a, wd, rnd);
      wait_done();
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
   endtask

   initial begin
      RESET     = 1'b1;
      READ      = 1'b0;
      WRITE     = 1'b0;
      ADDRESS   = 8'h00;
      WRITEDATA = 8'h00;
      MEM_READDATA = 32'h0;
      for (int k = 0; k < 64; k++) begin
         dev_mem[k] = $urandom;
         ref_mem[k] = dev_mem[k];
      end
      dev_mem[9] = 32'hDDCCBBAA;
      ref_mem[9] = 32'hDDCCBBAA;
      model_clear();

      // reset state
      @(posedge CLK); #1;
      READ = 1'b1;
      @(negedge CLK);
      chk("reset_busywait", BUSYWAIT, 0);
      chk("reset_mem_read", MEM_READ, 0);
      chk("reset_mem_write", MEM_WRITE, 0);
      @(posedge CLK); #1;
      READ  = 1'b0;
      RESET = 1'b0;
      @(negedge CLK);
      chk("reset_readdata", READDATA, 0);
      @(posedge CLK); #1;

      // cold read, write hit, read-back, dirty eviction, clean conflict
      do_req(1, 0, 8'h25, 0, 0);
      do_req(0, 1, 8'h26, 8'h77, 0);
      do_req(1, 0, 8'h26, 0, 0);
      do_req(1, 0, 8'hA6, 0, 0);
      do_req(1, 0, 8'h25, 0, 0);

      // reset on the third stall cycle of a clean miss
      issue(1, 0, 8'h45, 0, 0);
      for (int n = 0; n < 3; ) begin
         @(negedge CLK);
         if (BUSYWAIT) n++;
      end
      RESET = 1'b1;
      @(posedge CLK); #1;
      exp_q.delete();
      mop_q.delete();
      lat_q.delete();
      model_clear();
      @(negedge CLK);
      chk("rst_mid_busywait", BUSYWAIT, 0);
      chk("rst_mid_mem_read", MEM_READ, 0);
      @(posedge CLK); #1;
      RESET = 1'b0;
      READ  = 1'b0;
      do_req(1, 0, 8'h25, 0, 0);

      // idle: no request for ten cycles, uncached address reads as zero
      ADDRESS = 8'hFC;
      for (int n = 0; n < 10; n++) begin
         @(negedge CLK);
         chk("idle_busywait", BUSYWAIT, 0);
         chk("idle_strobes", {MEM_READ, MEM_WRITE}, 0);
      end
      chk("idle_readdata_miss", READDATA, 0);
      @(posedge CLK); #1;

      // READ and WRITE together act as a store
      do_req(1, 1, 8'h24, 8'h5A, 0);
      do_req(1, 0, 8'h24, 0, 0);

      // randomized traffic over a small set of tags/indices
      for (int k = 0; k < 80; k++) begin
         int a, rw;
         a  = int'($urandom_range(0, 3)) * 32
            + int'($urandom_range(0, 3)) * 4
            + int'($urandom_range(0, 3));
         rw = int'($urandom_range(0, 4));
         do_req(rw < 2 || rw == 4, rw >= 2, a, int'($urandom_range(0, 255)), 1);
         repeat ($urandom_range(0, 2)) @(posedge CLK);
         #1;
      end

      repeat (3) @(posedge CLK);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("mop_q_drained", mop_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
